// File: rtl/snake_game_ctrl_if.sv
// snake_game_ctrl_if
//   Groups the request/status signals of the snake game sequencer.
//   master : the environment side (drives keys, collisions, apple, grants)
//   slave  : the sequencer side (drives status, move_tick, flash, rewards)
//   Signals
//     start_key        one-cycle pulse, start/restart (and pause) request
//     hit_wall         level, wall collision
//     hit_body         level, self collision
//     add_cube         level, apple eaten (may stay high for many cycles)
//     slow_grant       one-cycle pulse, grant slow reward
//     protect_grant    one-cycle pulse, grant protect reward
//     game_status[1:0] 00 RESTART, 01 START, 10 PLAY, 11 DIE
//     move_tick        one-cycle step strobe
//     die_flash        1 = snake visible, 0 = hidden
//     reward_slowly    slow reward active
//     reward_protected protect reward active
//     speed_level[5:0] apples eaten this game, saturating at 63
//   Handshake: there is no valid/ready pair; every request is either a
//   single-cycle pulse sampled on the clock edge where it is high, or a
//   level sampled on every edge. No request is ever back-pressured.
interface snake_game_ctrl_if;
  logic       start_key;
  logic       hit_wall;
  logic       hit_body;
  logic       add_cube;
  logic       slow_grant;
  logic       protect_grant;
  logic [1:0] game_status;
  logic       move_tick;
  logic       die_flash;
  logic       reward_slowly;
  logic       reward_protected;
  logic [5:0] speed_level;

  modport master (
    output start_key, hit_wall, hit_body, add_cube, slow_grant, protect_grant,
    input  game_status, move_tick, die_flash, reward_slowly, reward_protected,
           speed_level
  );

  modport slave (
    input  start_key, hit_wall, hit_body, add_cube, slow_grant, protect_grant,
    output game_status, move_tick, die_flash, reward_slowly, reward_protected,
           speed_level
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
//   Game-status sequencer for the snake datapath: RESTART/START/PLAY/DIE FSM,
//   move_tick pacing with apple speed-up, slow/protect rewards timed in move
//   ticks, and the death blink on die_flash.
//   Ports
//     clk  : system clock
//     rst  : asynchronous active-low reset
//     bus  : snake_game_ctrl_if.slave (see interface file for signal list)
//   The FSM state is visible directly on bus.game_status (state encoding is
//   the status code).
//   Optional feature: define SNAKE_PAUSE_EN to let start_key toggle a pause
//   while in PLAY. Without it start_key is ignored in PLAY.
module snake_game_ctrl #(
  parameter int unsigned BASE_PERIOD  = 12_500_000,
  parameter int unsigned MIN_PERIOD   = 500_000,
  parameter int unsigned STEP         = 50_000,
  parameter int unsigned SLOW_PERIOD  = 20_000_000,
  parameter int unsigned FLASH_HALF   = 12_500_000,
  parameter int unsigned FLASH_COUNT  = 6,
  parameter int unsigned REWARD_TICKS = 40
) (
  input  logic             clk,
  input  logic             rst,
  snake_game_ctrl_if.slave bus
);

  localparam int FW = $clog2(FLASH_COUNT + 1);
  localparam logic [31:0]   BASE_P  = 32'(BASE_PERIOD);
  localparam logic [31:0]   MIN_P   = 32'(MIN_PERIOD);
  localparam logic [31:0]   STEP_P  = 32'(STEP);
  localparam logic [31:0]   SLOW_P  = 32'(SLOW_PERIOD);
  localparam logic [31:0]   HALF_P  = 32'(FLASH_HALF);
  localparam logic [FW-1:0] FLASH_N = FW'(FLASH_COUNT);
  localparam logic [5:0]    REW_N   = 6'(REWARD_TICKS);

  typedef enum logic [1:0] {
    ST_RESTART = 2'b00,
    ST_START   = 2'b01,
    ST_PLAY    = 2'b10,
    ST_DIE     = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [31:0] flash_cnt_q, flash_cnt_d;
  logic [FW-1:0] toggles_q, toggles_d;
  logic [5:0]  slow_cnt_q, slow_cnt_d;
  logic [5:0]  prot_cnt_q, prot_cnt_d;
  logic [5:0]  level_q, level_d;
  logic        move_tick_q, move_tick_d;
  logic        die_flash_q, die_flash_d;
  logic        slow_q, slow_d;
  logic        prot_q, prot_d;
  logic        add_prev_q, add_prev_d;
  logic        paused;
  logic        collision;
  logic        add_rise;
  logic [31:0] eff_period;

  assign collision  = bus.hit_wall | bus.hit_body;
  assign add_rise   = bus.add_cube & ~add_prev_q;
  assign eff_period = slow_q ? SLOW_P : period_q;

`ifdef SNAKE_PAUSE_EN
  logic paused_q, paused_d;

  // A collision always wins over a pause toggle and leaves the game unpaused.
  always_comb begin
    paused_d = paused_q;
    if (state_q == ST_RESTART) begin
      paused_d = 1'b0;
    end else if (state_q == ST_PLAY) begin
      if (collision)          paused_d = 1'b0;
      else if (bus.start_key) paused_d = ~paused_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) paused_q <= 1'b0;
    else      paused_q <= paused_d;
  end

  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    tick_cnt_d  = tick_cnt_q;
    flash_cnt_d = flash_cnt_q;
    toggles_d   = toggles_q;
    slow_cnt_d  = slow_cnt_q;
    prot_cnt_d  = prot_cnt_q;
    level_d     = level_q;
    move_tick_d = 1'b0;
    die_flash_d = die_flash_q;
    // Edge detector is frozen while paused so a held apple is not lost.
    add_prev_d  = (state_q == ST_PLAY && paused) ? add_prev_q : bus.add_cube;

    unique case (state_q)
      ST_RESTART: begin
        period_d    = BASE_P;
        level_d     = 6'd0;
        slow_cnt_d  = 6'd0;
        prot_cnt_d  = 6'd0;
        tick_cnt_d  = 32'd0;
        flash_cnt_d = 32'd0;
        toggles_d   = '0;
        die_flash_d = 1'b1;
        state_d     = ST_START;
      end
      ST_START: begin
        if (bus.start_key) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // Collision freezes everything else this cycle: no tick, no speed-up,
        // grants dropped, reward counters held into DIE.
        if (collision) begin
          state_d = ST_DIE;
        end else if (!paused) begin
          // >= rather than == so a period shortened below the running count
          // ticks immediately instead of wrapping through 2^32.
          if (tick_cnt_q >= eff_period - 32'd1) begin
            move_tick_d = 1'b1;
            tick_cnt_d  = 32'd0;
          end else begin
            tick_cnt_d  = tick_cnt_q + 32'd1;
          end
          // Rewards count the tick currently on move_tick; a grant reloads.
          if (bus.slow_grant)                         slow_cnt_d = REW_N;
          else if (move_tick_q && slow_cnt_q != 6'd0) slow_cnt_d = slow_cnt_q - 6'd1;
          if (bus.protect_grant)                      prot_cnt_d = REW_N;
          else if (move_tick_q && prot_cnt_q != 6'd0) prot_cnt_d = prot_cnt_q - 6'd1;
          if (add_rise) begin
            period_d = (period_q >= MIN_P + STEP_P) ? period_q - STEP_P : MIN_P;
            level_d  = (level_q == 6'd63) ? level_q : level_q + 6'd1;
          end
        end
      end
      ST_DIE: begin
        if (toggles_q != FLASH_N) begin
          if (flash_cnt_q >= HALF_P - 32'd1) begin
            flash_cnt_d = 32'd0;
            toggles_d   = toggles_q + FW'(1);
            die_flash_d = ~die_flash_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 32'd1;
          end
        end else if (bus.start_key) begin
          state_d = ST_RESTART;
        end
      end
    endcase

    slow_d = (slow_cnt_d != 6'd0);
    prot_d = (prot_cnt_d != 6'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RESTART;
      period_q    <= BASE_P;
      tick_cnt_q  <= 32'd0;
      flash_cnt_q <= 32'd0;
      toggles_q   <= '0;
      slow_cnt_q  <= 6'd0;
      prot_cnt_q  <= 6'd0;
      level_q     <= 6'd0;
      move_tick_q <= 1'b0;
      die_flash_q <= 1'b1;
      slow_q      <= 1'b0;
      prot_q      <= 1'b0;
      add_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      tick_cnt_q  <= tick_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      toggles_q   <= toggles_d;
      slow_cnt_q  <= slow_cnt_d;
      prot_cnt_q  <= prot_cnt_d;
      level_q     <= level_d;
      move_tick_q <= move_tick_d;
      die_flash_q <= die_flash_d;
      slow_q      <= slow_d;
      prot_q      <= prot_d;
      add_prev_q  <= add_prev_d;
    end
  end

  assign bus.game_status      = state_q;
  assign bus.move_tick        = move_tick_q;
  assign bus.die_flash        = die_flash_q;
  assign bus.reward_slowly    = slow_q;
  assign bus.reward_protected = prot_q;
  assign bus.speed_level      = level_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl
//   Self-checking bench for snake_game_ctrl with small timing parameters.
//   A cycle-level reference model (integer bookkeeping of the game rules)
//   predicts every output vector after each clock edge; the scoreboard queue
//   holds those predictions and each negedge compares the DUT against them.
//   Directed checks on tick spacing, reward lengths and the death blink use
//   constants from the game rules.
module tb_snake_game_ctrl;

  localparam int BASE_PERIOD  = 20;
  localparam int MIN_PERIOD   = 8;
  localparam int STEP         = 4;
  localparam int SLOW_PERIOD  = 40;
  localparam int FLASH_HALF   = 5;
  localparam int FLASH_COUNT  = 6;
  localparam int REWARD_TICKS = 3;
  localparam int W            = 12;

  logic clk;
  logic rst;

  snake_game_ctrl_if bus_if ();

  snake_game_ctrl #(
    .BASE_PERIOD (BASE_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD),
    .STEP        (STEP),
    .SLOW_PERIOD (SLOW_PERIOD),
    .FLASH_HALF  (FLASH_HALF),
    .FLASH_COUNT (FLASH_COUNT),
    .REWARD_TICKS(REWARD_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int slow_ticks_seen = 0;
  int prot_ticks_seen = 0;

  // ---------------- reference model ----------------
  // status: 0 RESTART, 1 START, 2 PLAY, 3 DIE
  int m_status, m_period, m_level, m_slow_cnt, m_prot_cnt;
  int m_elapsed, m_flash, m_ftimer, m_toggles, m_tick, m_add_prev, m_paused;

  task automatic push_expected();
    logic [W-1:0] v;
    v = {2'(m_status), 1'(m_tick), 1'(m_flash), (m_slow_cnt != 0),
         (m_prot_cnt != 0), 6'(m_level)};
    exp_q.push_back(v);
  endtask

  task automatic model_reset();
    m_status = 0; m_period = BASE_PERIOD; m_level = 0;
    m_slow_cnt = 0; m_prot_cnt = 0; m_elapsed = 0;
    m_flash = 1; m_ftimer = 0; m_toggles = 0; m_tick = 0;
    m_add_prev = 0; m_paused = 0;
    push_expected();
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    int  old_status, old_tick, old_paused, eff;
    bit  col, add_rise;
    if (!rst) begin
      model_reset();
      return;
    end
    old_status = m_status;
    old_tick   = m_tick;
    old_paused = m_paused;
    col        = bus_if.hit_wall || bus_if.hit_body;
    add_rise   = bus_if.add_cube && (m_add_prev == 0);
    m_tick     = 0;
    case (old_status)
      0: begin
        m_period = BASE_PERIOD; m_level = 0; m_slow_cnt = 0; m_prot_cnt = 0;
        m_elapsed = 0; m_flash = 1; m_ftimer = 0; m_toggles = 0; m_paused = 0;
        m_status = 1;
      end
      1: if (bus_if.start_key) m_status = 2;
      2: begin
        if (col) begin
          m_status = 3;
          m_paused = 0;
        end else if (old_paused != 0) begin
          if (bus_if.start_key) m_paused = 0;
        end else begin
          eff = (m_slow_cnt != 0) ? SLOW_PERIOD : m_period;
          m_elapsed++;
          if (m_elapsed >= eff) begin
            m_tick = 1;
            m_elapsed = 0;
          end
          if (bus_if.slow_grant) m_slow_cnt = REWARD_TICKS;
          else if (old_tick != 0 && m_slow_cnt > 0) m_slow_cnt--;
          if (bus_if.protect_grant) m_prot_cnt = REWARD_TICKS;
          else if (old_tick != 0 && m_prot_cnt > 0) m_prot_cnt--;
          if (add_rise) begin
            m_period = (m_period - STEP < MIN_PERIOD) ? MIN_PERIOD : m_period - STEP;
            if (m_level < 63) m_level++;
          end
`ifdef SNAKE_PAUSE_EN
          if (bus_if.start_key) m_paused = 1;
`endif
        end
      end
      default: begin
        if (m_toggles < FLASH_COUNT) begin
          m_ftimer++;
          if (m_ftimer == FLASH_HALF) begin
            m_flash = 1 - m_flash;
            m_toggles++;
            m_ftimer = 0;
          end
        end else if (bus_if.start_key) begin
          m_status = 0;
        end
      end
    endcase
    if (!(old_status == 2 && old_paused != 0)) m_add_prev = bus_if.add_cube ? 1 : 0;
    push_expected();
  endtask

  // ---------------- checkers ----------------
  task automatic check(input string tag);
    logic [W-1:0] exp_v, obs_v;
    obs_v = {bus_if.game_status, bus_if.move_tick, bus_if.die_flash,
             bus_if.reward_slowly, bus_if.reward_protected, bus_if.speed_level};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs_v);
      return;
    end
    exp_v = exp_q.pop_front();
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (status,tick,flash,slow,prot,level)",
             tag, obs_v, exp_v);
    end
  endtask

  task automatic expect_val(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag);
    if (bus_if.move_tick && bus_if.reward_slowly)    slow_ticks_seen++;
    if (bus_if.move_tick && bus_if.reward_protected) prot_ticks_seen++;
  endtask

  task automatic pulse_start(input string tag);
    bus_if.start_key = 1'b1;
    cycle(tag);
    bus_if.start_key = 1'b0;
  endtask

  // Counts cycles until the next move_tick (inclusive) and checks the gap.
  task automatic measure_spacing(input int exp_gap, input string tag);
    int n;
    n = 0;
    do begin
      cycle(tag);
      n++;
    end while (!bus_if.move_tick && n < 200);
    expect_val(tag, n, exp_gap);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      cycle(tag);
      n++;
    end while (!bus_if.move_tick && n < 200);
    expect_val({tag, "_timeout"}, int'(bus_if.move_tick), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int level_before, toggles, last_toggle, prev_flash, n;
    rst = 1'b0;
    bus_if.start_key = 1'b0; bus_if.hit_wall = 1'b0; bus_if.hit_body = 1'b0;
    bus_if.add_cube = 1'b0; bus_if.slow_grant = 1'b0; bus_if.protect_grant = 1'b0;

    // 1. reset, START, PLAY, base tick spacing
    @(negedge clk);
    model_reset();
    check("reset_values");
    @(negedge clk);
    rst = 1'b1;
    cycle("restart_to_start");
    expect_val("status_start", int'(bus_if.game_status), 1);
    repeat ($urandom_range(2, 6)) cycle("start_idle");
    pulse_start("enter_play");
    expect_val("status_play", int'(bus_if.game_status), 2);
    measure_spacing(BASE_PERIOD, "first_tick");
    measure_spacing(BASE_PERIOD, "base_gap");

    // 2. apple speed-up, add_cube held for 10 cycles each time
    for (int k = 0; k < 4; k++) begin
      bus_if.add_cube = 1'b1;
      repeat (10) cycle("apple_held");
      bus_if.add_cube = 1'b0;
      repeat ($urandom_range(2, 6)) cycle("apple_gap");
    end
    expect_val("speed_level_4", int'(bus_if.speed_level), 4);
    wait_tick("fast_align");
    measure_spacing(MIN_PERIOD, "fast_gap");

    // 3. slow reward with a re-grant after two slow ticks
    repeat ($urandom_range(1, 5)) cycle("pre_slow");
    slow_ticks_seen = 0;
    bus_if.slow_grant = 1'b1;
    cycle("slow_grant");
    bus_if.slow_grant = 1'b0;
    wait_tick("slow_t1");
    wait_tick("slow_t2");
    cycle("slow_pre_regrant");
    bus_if.slow_grant = 1'b1;
    cycle("slow_regrant");
    bus_if.slow_grant = 1'b0;
    wait_tick("slow_t3");
    measure_spacing(SLOW_PERIOD, "slow_gap");
    n = 0;
    while (bus_if.reward_slowly && n < 400) begin
      cycle("slow_drain");
      n++;
    end
    expect_val("slow_ticks_total", slow_ticks_seen, 5);
    wait_tick("post_slow_align");
    measure_spacing(MIN_PERIOD, "post_slow_gap");

    // 4. protect grant coincident with a move_tick
    wait_tick("prot_align");
    prot_ticks_seen = 0;
    bus_if.protect_grant = 1'b1;
    cycle("prot_grant_on_tick");
    bus_if.protect_grant = 1'b0;
    expect_val("prot_active", int'(bus_if.reward_protected), 1);
    n = 0;
    while (bus_if.reward_protected && n < 200) begin
      cycle("prot_drain");
      n++;
    end
    expect_val("prot_ticks_total", prot_ticks_seen, REWARD_TICKS);

    // 5. random play, no collisions; start_key in PLAY must be ignored
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) bus_if.add_cube = ~bus_if.add_cube;
      bus_if.slow_grant    = ($urandom_range(0, 29) == 0);
      bus_if.protect_grant = ($urandom_range(0, 29) == 0);
`ifndef SNAKE_PAUSE_EN
      bus_if.start_key     = ($urandom_range(0, 39) == 0);
`endif
      cycle("random_play");
    end
    bus_if.slow_grant = 1'b0; bus_if.protect_grant = 1'b0; bus_if.start_key = 1'b0;
    bus_if.add_cube = 1'b0;
    cycle("random_settle");

    // 6. wall hit together with an apple edge, death blink, restart
    level_before = m_level;
    bus_if.hit_wall = 1'b1;
    bus_if.add_cube = 1'b1;
    cycle("collide");
    bus_if.hit_wall = 1'b0;
    bus_if.add_cube = 1'b0;
    expect_val("status_die", int'(bus_if.game_status), 3);
    expect_val("level_kept", int'(bus_if.speed_level), level_before);
    toggles = 0; last_toggle = 0; prev_flash = int'(bus_if.die_flash);
    for (int i = 1; i <= 40; i++) begin
      bus_if.start_key = (i < 28) && ($urandom_range(0, 3) == 0);
      cycle("die_flash");
      bus_if.start_key = 1'b0;
      if (int'(bus_if.die_flash) != prev_flash) begin
        toggles++;
        last_toggle = i;
      end
      prev_flash = int'(bus_if.die_flash);
    end
    expect_val("flash_toggles", toggles, FLASH_COUNT);
    expect_val("flash_last_at", last_toggle, FLASH_COUNT * FLASH_HALF);
    expect_val("flash_end_vis", int'(bus_if.die_flash), 1);
    expect_val("still_die", int'(bus_if.game_status), 3);
    pulse_start("die_to_restart");
    expect_val("status_restart", int'(bus_if.game_status), 0);
    cycle("restart_to_start2");
    expect_val("level_cleared", int'(bus_if.speed_level), 0);
    pulse_start("enter_play2");
    measure_spacing(BASE_PERIOD, "regame_first_tick");

    // 7. async reset mid-PLAY with rewards active
    bus_if.slow_grant = 1'b1; bus_if.protect_grant = 1'b1;
    cycle("grant_both");
    bus_if.slow_grant = 1'b0; bus_if.protect_grant = 1'b0;
    repeat ($urandom_range(3, 12)) cycle("rewarded_play");
    rst = 1'b0;
    #1;
    model_reset();
    check("async_reset");
    @(negedge clk);
    repeat (3) cycle("held_reset");
    rst = 1'b1;
    repeat ($urandom_range(10, 20)) cycle("start_no_tick");
    pulse_start("enter_play3");
    repeat ($urandom_range(20, 35)) cycle("play3");
    bus_if.hit_body = 1'b1;
    cycle("body_hit");
    bus_if.hit_body = 1'b0;
    expect_val("status_die_body", int'(bus_if.game_status), 3);
    repeat (12) cycle("die2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
